// File: rtl/instr_sequencer_if.sv
// Phase-strobe / ROM / status bundle between the phase state machine and the
// instruction sequencer. The state machine (and ROM) side is the master.
interface instr_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              fetch;
  logic              exec1;
  logic              exec2;
  logic [15:0]       instr;
  logic [ADDR_W-1:0] pc;
  logic [15:0]       ir;
  logic              extra;
  logic              p;
  logic              done;
  logic              err;

  modport master (
    output fetch, exec1, exec2, instr,
    input  pc, ir, extra, p, done, err
  );

  modport slave (
    input  fetch, exec1, exec2, instr,
    output pc, ir, extra, p, done, err
  );
endinterface

// File: rtl/instr_sequencer.sv
// Fetch/decode companion to the CPU phase state machine. Owns PC, IR and the
// repeat counter; tells the state machine when an instruction needs EXEC2 or
// another execute pass, and flags when it retires.
module instr_sequencer #(
  parameter int          ADDR_W       = 8,
  parameter logic [11:0] RESET_PC     = 12'd0,
  parameter logic [15:0] TWO_CYC_MASK = 16'h00F0,
  parameter logic [15:0] REP_MASK     = 16'h0300,
  parameter logic [3:0]  JMP_OP       = 4'hF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  instr_sequencer_if.slave  bus
);

  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_ir;
  logic [3:0]        r_rep_cnt;
  logic              r_err;

  logic              w_legal;
  logic [3:0]        w_op;
  logic              w_extra;
  logic              w_p;
  logic              w_pass_end;
  logic              w_done;
  logic              w_rep_nz;
  logic [ADDR_W-1:0] w_jmp_pc;
  logic [ADDR_W-1:0] w_reset_pc;
  logic [ADDR_W+11:0] w_jmp_ext;
  logic [ADDR_W+11:0] w_rst_ext;

  // Phase decode and same-cycle status towards the state machine
  always_comb begin
    w_legal    = $onehot({bus.fetch, bus.exec1, bus.exec2});
    w_op       = r_ir[15:12];
    w_rep_nz   = (r_rep_cnt != 4'd0);
    w_extra    = w_legal & bus.exec1 & TWO_CYC_MASK[w_op];
    w_p        = w_legal & w_rep_nz & (bus.exec1 | bus.exec2);
    w_pass_end = w_legal & ((bus.exec1 & ~w_extra) | bus.exec2);
    w_done     = w_pass_end & ~w_rep_nz;
    // Jump target is IR[11:0] truncated or zero-extended to the PC width
    w_jmp_ext  = {{ADDR_W{1'b0}}, r_ir[11:0]};
    w_jmp_pc   = w_jmp_ext[ADDR_W-1:0];
    w_rst_ext  = {{ADDR_W{1'b0}}, RESET_PC};
    w_reset_pc = w_rst_ext[ADDR_W-1:0];
  end

  // PC, IR, repeat counter and sticky error
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc      <= w_reset_pc;
      r_ir      <= 16'h0000;
      r_rep_cnt <= 4'd0;
      r_err     <= 1'b0;
    end else if (!w_legal) begin
      r_err <= 1'b1;
    end else begin
      if (bus.fetch) begin
        r_ir      <= bus.instr;
        r_pc      <= r_pc + 1'b1;
        r_rep_cnt <= REP_MASK[bus.instr[15:12]] ? bus.instr[3:0] : 4'd0;
      end
      if (w_pass_end && w_rep_nz)
        r_rep_cnt <= r_rep_cnt - 4'd1;
      if (w_done && (w_op == JMP_OP))
        r_pc <= w_jmp_pc;
    end
  end

  assign bus.pc    = r_pc;
  assign bus.ir    = r_ir;
  assign bus.extra = w_extra;
  assign bus.p     = w_p;
  assign bus.done  = w_done;
  assign bus.err   = r_err;

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

  logic        clk;
  logic        rst;
  logic        fetch, exec1, exec2;
  logic [15:0] instr;

  int n_cmp;
  int n_bad;

  instr_sequencer_if #(.ADDR_W(8)) bus1 ();
  instr_sequencer_if #(.ADDR_W(8)) bus2 ();

  assign bus1.fetch = fetch;
  assign bus1.exec1 = exec1;
  assign bus1.exec2 = exec2;
  assign bus1.instr = instr;
  assign bus2.fetch = fetch;
  assign bus2.exec1 = exec1;
  assign bus2.exec2 = exec2;
  assign bus2.instr = instr;

  instr_sequencer #(.ADDR_W(8)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus1.slave)
  );

  // second instance: opcode 9 is both repeatable and two-cycle
  instr_sequencer #(
    .ADDR_W       (8),
    .TWO_CYC_MASK (16'h02F0),
    .REP_MASK     (16'h0300)
  ) dut2 (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        f, e1, e2;
    logic [15:0] ins;
    logic        x_extra, x_p, x_done;
    logic [7:0]  x_pc;
    logic [15:0] x_ir;
    logic        x_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic f, input logic e1, input logic e2, input logic [15:0] ins);
    fetch = f; exec1 = e1; exec2 = e2; instr = ins;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic f, input logic e1, input logic e2, input logic [15:0] ins,
                              input logic xe, input logic xp, input logic xd,
                              input logic [7:0] xpc, input logic [15:0] xir, input logic xerr);
    vec_t v;
    v.f = f; v.e1 = e1; v.e2 = e2; v.ins = ins;
    v.x_extra = xe; v.x_p = xp; v.x_done = xd;
    v.x_pc = xpc; v.x_ir = xir; v.x_err = xerr;
    return v;
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0);

    //            F  E1 E2 INSTR     EXT P  DONE PC     IR        ERR
    vecs.push_back(mk(1, 0, 0, 16'h1000, 0, 0, 0, 8'h01, 16'h1000, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 0, 1, 8'h01, 16'h1000, 0));
    vecs.push_back(mk(1, 0, 0, 16'h5000, 0, 0, 0, 8'h02, 16'h5000, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 0, 0, 8'h02, 16'h5000, 0));
    vecs.push_back(mk(0, 0, 1, 16'h0000, 0, 0, 1, 8'h02, 16'h5000, 0));
    vecs.push_back(mk(1, 0, 0, 16'h8003, 0, 0, 0, 8'h03, 16'h8003, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 0, 8'h03, 16'h8003, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 0, 8'h03, 16'h8003, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 0, 8'h03, 16'h8003, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 0, 1, 8'h03, 16'h8003, 0));
    vecs.push_back(mk(1, 0, 0, 16'hF0FF, 0, 0, 0, 8'h04, 16'hF0FF, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 0, 1, 8'hFF, 16'hF0FF, 0));
    vecs.push_back(mk(1, 0, 0, 16'hF0A5, 0, 0, 0, 8'h00, 16'hF0A5, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 0, 1, 8'hA5, 16'hF0A5, 0));
    vecs.push_back(mk(1, 1, 0, 16'h1234, 0, 0, 0, 8'hA5, 16'hF0A5, 1));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 8'hA5, 16'hF0A5, 1));
    vecs.push_back(mk(1, 0, 0, 16'h1000, 0, 0, 0, 8'hA6, 16'h1000, 1));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 0, 1, 8'hA6, 16'h1000, 1));

    do_reset();
    chk("rst_pc",  {24'h0, bus1.pc}, 32'h0);
    chk("rst_ir",  {16'h0, bus1.ir}, 32'h0);
    chk("rst_err", {31'h0, bus1.err}, 32'h0);
    chk("rst_idle_done", {31'h0, bus1.done}, 32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].f, vecs[i].e1, vecs[i].e2, vecs[i].ins);
      @(negedge clk);
      chk($sformatf("v%0d_extra", i), {31'h0, bus1.extra}, {31'h0, vecs[i].x_extra});
      chk($sformatf("v%0d_p", i),     {31'h0, bus1.p},     {31'h0, vecs[i].x_p});
      chk($sformatf("v%0d_done", i),  {31'h0, bus1.done},  {31'h0, vecs[i].x_done});
      @(posedge clk); #1;
      chk($sformatf("v%0d_pc", i),  {24'h0, bus1.pc},  {24'h0, vecs[i].x_pc});
      chk($sformatf("v%0d_ir", i),  {16'h0, bus1.ir},  {16'h0, vecs[i].x_ir});
      chk($sformatf("v%0d_err", i), {31'h0, bus1.err}, {31'h0, vecs[i].x_err});
    end

    // reset clears sticky ERR
    do_reset();
    chk("rst2_err", {31'h0, bus1.err}, 32'h0);
    chk("rst2_pc",  {24'h0, bus1.pc},  32'h0);

    // reset mid-instruction: repeat count and IR are dropped
    drive(1'b1, 1'b0, 1'b0, 16'h8003);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 16'h0);
    @(negedge clk);
    chk("mid_p_before", {31'h0, bus1.p}, 32'h1);
    @(posedge clk); #1;
    do_reset();
    chk("mid_ir", {16'h0, bus1.ir}, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 16'h0);
    @(negedge clk);
    chk("mid_p_after",    {31'h0, bus1.p},    32'h0);
    chk("mid_done_after", {31'h0, bus1.done}, 32'h1);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 16'h2000);
    @(posedge clk); #1;
    chk("mid_refetch_pc", {24'h0, bus1.pc}, 32'h1);
    chk("mid_refetch_ir", {16'h0, bus1.ir}, 32'h2000);

    // repeat + two-cycle on the custom-mask instance
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 16'h9001);
    @(posedge clk); #1;
    chk("c_pc", {24'h0, bus2.pc}, 32'h1);
    chk("c_ir", {16'h0, bus2.ir}, 32'h9001);
    for (int k = 0; k < 4; k++) begin
      logic e1;
      logic xe, xp, xd;
      e1 = (k % 2 == 0);
      xe = e1;
      xp = (k < 2);
      xd = (k == 3);
      drive(1'b0, e1, ~e1, 16'h0);
      @(negedge clk);
      chk($sformatf("c%0d_extra", k), {31'h0, bus2.extra}, {31'h0, xe});
      chk($sformatf("c%0d_p", k),     {31'h0, bus2.p},     {31'h0, xp});
      chk($sformatf("c%0d_done", k),  {31'h0, bus2.done},  {31'h0, xd});
      @(posedge clk); #1;
    end
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    @(posedge clk); #1;
    chk("c_err", {31'h0, bus2.err}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
